// File: rtl/t07_ssdec_spi_engine.sv
// SPI front end for a serial seven-segment display: builds a command/segment byte list
// from a snapshot of the inputs and shifts it out in SPI mode 0, MSB first.
module t07_ssdec_spi_engine #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 4,
    parameter int unsigned GAP_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    cont,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [7:0]              dp_mask,
    input  logic [7:0]              brightness,
    output logic                    ss,
    output logic                    sck,
    output logic                    sdi,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned NUM_BYTES = 5 + 2 * NUM_DIGITS;
    localparam int unsigned BYTE_W    = $clog2(NUM_BYTES);
    localparam int unsigned GAP_LEN   = 2 * DIV * GAP_BITS;
    localparam int unsigned GAP_W     = $clog2(GAP_LEN);
    localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_GAP, S_DONE
    } state_t;

    function automatic logic [7:0] seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
            4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
            4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
            4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  default: s = 8'h71;
        endcase
        return s;
    endfunction

    // Byte idx of the full (first-frame) list; refresh frames simply start at index 1.
    function automatic logic [7:0] byte_at(input logic [BYTE_W-1:0]     idx,
                                           input logic [4*NUM_DIGITS-1:0] dg,
                                           input logic [7:0]              dp,
                                           input logic [7:0]              br);
        logic [7:0]        b;
        logic [BYTE_W-1:0] j;
        int unsigned       dig;
        b   = 8'h00;
        j   = '0;
        dig = 0;
        if (idx == BYTE_W'(0))      b = 8'h76;
        else if (idx == BYTE_W'(1)) b = 8'h7A;
        else if (idx == BYTE_W'(2)) b = br;
        else if (idx == BYTE_W'(3)) b = 8'h77;
        else if (idx == BYTE_W'(4)) b = dp;
        else begin
            j   = idx - BYTE_W'(5);
            dig = 32'(j >> 1);
            if (dig < NUM_DIGITS) begin
                if (j[0]) b = seg(dg[4*dig +: 4]);
                else      b = 8'h7B + 8'(dig);
            end
        end
        return b;
    endfunction

    state_t                  state, state_nx;
    logic [DIV_W-1:0]        div_cnt, div_nx;
    logic [2:0]              bit_idx, bit_nx;
    logic [BYTE_W-1:0]       byte_idx, byte_nx;
    logic [GAP_W-1:0]        gap_cnt, gap_nx;
    logic                    refresh, refresh_nx;
    logic [4*NUM_DIGITS-1:0] snap_digits, src_digits;
    logic [7:0]              snap_dp, snap_br, src_dp, src_br, cur_byte;
    logic                    ss_d, sck_d, sdi_d, busy_d, done_d;

    // State register, counters, frame snapshot and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            refresh     <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_br     <= '0;
            ss          <= 1'b1;
            sck         <= 1'b0;
            sdi         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            bit_idx  <= bit_nx;
            byte_idx <= byte_nx;
            gap_cnt  <= gap_nx;
            refresh  <= refresh_nx;
            if (state == S_LOAD) begin
                snap_digits <= digits;
                snap_dp     <= dp_mask;
                snap_br     <= brightness;
            end
            ss   <= ss_d;
            sck  <= sck_d;
            sdi  <= sdi_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Next state and next counter values.
    always_comb begin
        state_nx   = state;
        div_nx     = div_cnt;
        bit_nx     = bit_idx;
        byte_nx    = byte_idx;
        gap_nx     = gap_cnt;
        refresh_nx = refresh;
        if (clear) begin
            state_nx   = S_IDLE;
            div_nx     = '0;
            bit_nx     = '0;
            byte_nx    = '0;
            gap_nx     = '0;
            refresh_nx = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_nx     = '0;
                    bit_nx     = '0;
                    byte_nx    = '0;
                    gap_nx     = '0;
                    refresh_nx = 1'b0;
                    if (start) state_nx = S_LOAD;
                end
                S_LOAD: begin
                    state_nx = S_SHIFT_LO;
                    div_nx   = '0;
                    bit_nx   = 3'd7;
                    byte_nx  = refresh ? BYTE_W'(1) : '0;
                end
                S_SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_nx   = '0;
                        state_nx = S_SHIFT_HI;
                    end else begin
                        div_nx = div_cnt + DIV_W'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_nx = '0;
                        if (bit_idx == 3'd0) begin
                            state_nx = S_GAP;
                            gap_nx   = '0;
                        end else begin
                            bit_nx   = bit_idx - 3'd1;
                            state_nx = S_SHIFT_LO;
                        end
                    end else begin
                        div_nx = div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_nx = '0;
                        if (byte_idx == LAST_BYTE) begin
                            state_nx = S_DONE;
                        end else begin
                            byte_nx  = byte_idx + BYTE_W'(1);
                            bit_nx   = 3'd7;
                            state_nx = S_SHIFT_LO;
                        end
                    end else begin
                        gap_nx = gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    byte_nx = '0;
                    bit_nx  = '0;
                    if (cont) begin
                        state_nx   = S_LOAD;
                        refresh_nx = 1'b1;
                    end else begin
                        state_nx   = S_IDLE;
                        refresh_nx = 1'b0;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so the registers track the state exactly.
    always_comb begin
        ss_d       = 1'b1;
        sck_d      = 1'b0;
        sdi_d      = 1'b0;
        busy_d     = (state_nx != S_IDLE);
        done_d     = (state_nx == S_DONE);
        src_digits = (state == S_LOAD) ? digits     : snap_digits;
        src_dp     = (state == S_LOAD) ? dp_mask    : snap_dp;
        src_br     = (state == S_LOAD) ? brightness : snap_br;
        cur_byte   = byte_at(byte_nx, src_digits, src_dp, src_br);
        if (state_nx == S_SHIFT_LO || state_nx == S_SHIFT_HI) begin
            ss_d  = 1'b0;
            sck_d = (state_nx == S_SHIFT_HI);
            sdi_d = cur_byte[bit_nx];
        end
    end

endmodule

// File: doc/t07_ssdec_spi_engine.md
T07_SSDEC_SPI_ENGINE -- requirements
Module: t07_ssdec_spi_engine

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of display digits driven (1..4).
REQ-002 SHALL have parameter DIV, default 4, SCK half-period in clk cycles (>=1).
REQ-003 SHALL have parameter GAP_BITS, default 16, inter-byte gap in SCK periods with ss high (>=1).
REQ-004 SHALL have port clk  input  1  system clock; sole clock domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clear  input  1  synchronous abort of any transfer.
REQ-007 SHALL have port start  input  1  single-cycle request to begin a frame.
REQ-008 SHALL have port cont  input  1  continuous-refresh mode select.
REQ-009 SHALL have port digits  input  4*NUM_DIGITS  hex value per digit, digit 0 in bits [3:0].
REQ-010 SHALL have port dp_mask  input  8  decimal/colon control byte.
REQ-011 SHALL have port brightness  input  8  display brightness byte.
REQ-012 SHALL have port ss  output  1  SPI slave select, active-low.
REQ-013 SHALL have port sck  output  1  SPI clock, mode 0 (idle low).
REQ-014 SHALL have port sdi  output  1  SPI MOSI, MSB first.
REQ-015 SHALL have port busy  output  1  high from accepted start until return to IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of each frame.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT_LO, SHIFT_HI, GAP, DONE.
REQ-018 IDLE: start=1 -> LOAD next cycle, busy=1; start while busy SHALL be ignored.
REQ-019 LOAD (1 cycle): snapshot digits, dp_mask, brightness; build byte list; byte index=0; -> SHIFT_LO.
REQ-020 First frame after start: bytes 0x76, 0x7A, brightness, 0x77, dp_mask, then per digit i=0..NUM_DIGITS-1: 0x7B+i, seg(digits[i]); 5+2*NUM_DIGITS bytes.
REQ-021 Refresh frames (cont=1): identical but without leading 0x76; 4+2*NUM_DIGITS bytes.
REQ-022 seg(): bit0=a..bit6=g, bit7=0; 0->0x3F,1->0x06,2->0x5B,3->0x4F,4->0x66,5->0x6D,6->0x7D,7->0x07,8->0x7F,9->0x6F,A->0x77,b->0x7C,C->0x39,d->0x5E,E->0x79,F->0x71.
REQ-023 SHIFT_LO: ss=0, sck=0, sdi=current bit, held DIV cycles; -> SHIFT_HI.
REQ-024 SHIFT_HI: sck=1 held DIV cycles; after bit 0 of byte -> GAP, else next bit -> SHIFT_LO.
REQ-025 Each byte SHALL occupy exactly 16*DIV clk cycles with ss low; sdi stable across the sck rising edge.
REQ-026 GAP: ss=1, sck=0, sdi=0 for 2*DIV*GAP_BITS cycles; then next byte -> SHIFT_LO, or after last byte -> DONE.
REQ-027 DONE (1 cycle): done=1; cont=1 -> LOAD (refresh, resnapshot inputs); cont=0 -> IDLE, busy=0 in IDLE.
REQ-028 Inputs changing mid-frame SHALL NOT affect the frame in progress.
REQ-029 clear=1 SHALL, next cycle, force IDLE, ss=1, sck=0, sdi=0, busy=0, done=0, counters 0; clear dominates start.
REQ-030 Divider and bit/byte/gap counters SHALL be internal and held at 0 in IDLE.

Reset
REQ-031 rst=1 SHALL immediately set ss=1, sck=0, sdi=0, busy=0, done=0, state IDLE, all counters and shift data 0.
REQ-032 rst asserted mid-byte SHALL abort without completing the byte; after release, no transfer until a new start.

Verification
REQ-033 DIV=2, GAP_BITS=2, NUM_DIGITS=4, digits=0x4321, brightness=0xFF, dp_mask=0x00, start pulse, cont=0 -> 13 bytes decoded on sck rise: 76 7A FF 77 00 7B 06 7C 5B 7D 4F 7E 66; done once; busy low after.
REQ-034 Same setup, cont=1 -> first frame 13 bytes, second frame 12 bytes starting 7A; digits changed to 0x8888 mid-frame-1 -> only frame 2 shows 7F.
REQ-035 DIV=2: measure per byte ss low exactly 32 clk cycles, 8 sck rising edges, gap ss high exactly 8 cycles.
REQ-036 clear asserted after 3rd sck rise of byte 2 -> next cycle ss=1, sck=0, busy=0; no done pulse; later start gives full 13-byte frame.
REQ-037 rst pulse mid-frame -> outputs at reset values asynchronously; start while busy (second pulse mid-frame) -> ignored, frame byte count unchanged.
REQ-038 NUM_DIGITS=1, digits=0xF -> 7 bytes: 76 7A bb 77 mm 7B 71.
